m_execution_unit: RTL and testbench
===================================

Name: m_execution_unit

Overview:
- Iterative multiply/divide execution unit implementing the RV32M R-type group: opcode 0110011, funct7 0000001.
- Sits beside the combinational R-type execution unit.
- The core issues one operation through a valid/ready handshake and stalls until the result is returned.
- Datapath width is parametrised. One quotient or product bit is resolved per cycle, with single-cycle fast paths for divide special cases.

Parameters:
- WIDTH, 32: operand/result width in bits; minimum 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA  input  WIDTH  rs1 value
- opB  input  WIDTH  rs2 value
- kill  input  1  abort the in-flight operation (pipeline flush)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  rd value

Behaviour:
- Reset (rst low, asynchronous): state IDLE; in_ready=1; out_valid=0; result=0; counter and working registers cleared. Reset mid-operation discards that operation.
- States are IDLE, CALC and DONE.
- in_ready = (state==IDLE). Accept occurs on in_valid && in_ready. funct3, opA and opB are captured at acceptance; later input changes have no effect.
- IDLE -> CALC on accept. The counter loads WIDTH. Sign-adjusted magnitudes are formed at capture:
  - MULH: both operands signed.
  - MULHSU: opA signed, opB unsigned.
  - MULHU: both unsigned.
  - MUL: sign is irrelevant to the low half.
  - DIV/REM: both operands signed.
  - DIVU/REMU: both unsigned.
- IDLE -> DONE directly on accept (fast path), with the result loaded in the same edge, in two cases:
  - Divide by zero (opB==0, funct3[2]=1): DIV/DIVU give all ones; REM/REMU give opA.
  - Signed overflow (DIV/REM, opA==1<<(WIDTH-1), opB==all ones): DIV gives opA; REM gives 0.
- CALC (multiply): shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
- CALC (divide): restoring division, one quotient bit per cycle, with a WIDTH+1-bit remainder.
- CALC lasts exactly WIDTH cycles; the counter decrements each cycle. At count 1, CALC -> DONE.
- Result selection and sign fix-up happen in the CALC->DONE edge:
  - MUL: low WIDTH bits.
  - MULH*: high WIDTH bits of the sign-corrected 2*WIDTH product.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Latency from the accept edge to out_valid high: WIDTH+1 cycles normal (33 at WIDTH=32); 1 cycle on the fast path.
- DONE: out_valid=1 and result is held stable until out_valid && out_ready. That edge moves to IDLE; out_valid drops and in_ready rises the next cycle. No accept occurs in DONE, so there is one bubble between operations.
- kill: in CALC or DONE, the next state is IDLE, out_valid=0, and the result is never presented. kill in IDLE has no effect. In DONE, if kill and out_ready are both high, kill wins: no handshake counts.
- in_valid held in CALC/DONE is ignored; the requester holds it until in_ready.
- All arithmetic is modulo 2^WIDTH. There are no exceptions and no error outputs.

Decomposition:
- Shared package m_ext_pkg holds:
  - OPCODE_OP (0110011) and FUNCT7_MULDIV (0000001).
  - The eight funct3 constants above.
  - The state enum IDLE/CALC/DONE.
- One sub-module is natural: m_sign_fixup, a combinational conditional two's-complement negate of WIDTH bits. It is instantiated for operand magnitude capture and for result correction.
- Counter, FSM and the shift-add/restoring-division datapath stay in m_execution_unit. One shared 2*WIDTH+1 working register serves both multiply and divide.

Test Plan:
- MUL opA=7, opB=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid rises exactly 33 cycles after the accept edge; in_ready low throughout.
- opA=opB=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable. Change opA/opB during CALC -> result unaffected. in_ready returns 1 cycle after the handshake.
- kill at CALC cycle 5 -> IDLE next cycle, no out_valid. A following MULHU 3*5 -> 0. Drop rst asynchronously mid-CALC -> outputs reset immediately with no clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide unit.
package m_ext_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/m_execution_unit_sign_fixup.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module m_sign_fixup #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] data_o
);

   assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/m_execution_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero and overflow.
module m_execution_unit
   import m_ext_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH:0]   work_q, work_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               sign_a, sign_b, neg_a, neg_b, is_div, div_zero, div_ovf;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, rem_shift;
   logic [WIDTH+1:0]   diff;
   logic               fits;
   logic [2*WIDTH:0]   step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign is_div   = funct3[2];
   assign sign_a   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
   assign sign_b   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
   assign neg_a    = sign_a & opA[WIDTH-1];
   assign neg_b    = sign_b & opB[WIDTH-1];
   assign div_zero = is_div && (opB == '0);
   assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (opA == {1'b1, {(WIDTH-1){1'b0}}}) && (opB == '1);

   m_sign_fixup #(.WIDTH(WIDTH)) u_mag_a (.data_i(opA), .neg_i(neg_a), .data_o(mag_a));
   m_sign_fixup #(.WIDTH(WIDTH)) u_mag_b (.data_i(opB), .neg_i(neg_b), .data_o(mag_b));

   // One iteration: multiply keeps {carry, hi, multiplier}; divide keeps {rem, dividend/quot}.
   always_comb begin
      mul_sum   = work_q[2*WIDTH:WIDTH] + (work_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      diff      = {1'b0, rem_shift} - {2'b00, opnd_q};
      fits      = ~diff[WIDTH+1];
      if (op_q[2]) begin
         step = {(fits ? diff[WIDTH:0] : rem_shift), work_q[WIDTH-2:0], fits};
      end else begin
         step = {1'b0, mul_sum, work_q[WIDTH-1:1]};
      end
   end

   m_sign_fixup #(.WIDTH(2*WIDTH)) u_prod_fix (
      .data_i(step[2*WIDTH-1:0]), .neg_i(neg_q), .data_o(prod_fix)
   );
   m_sign_fixup #(.WIDTH(WIDTH)) u_quot_fix (
      .data_i(step[WIDTH-1:0]), .neg_i(neg_q), .data_o(quot_fix)
   );
   m_sign_fixup #(.WIDTH(WIDTH)) u_rem_fix (
      .data_i(step[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .data_o(rem_fix)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d      = funct3;
               neg_d     = neg_a ^ neg_b;
               neg_rem_d = neg_a;
               cnt_d     = CNT_W'(WIDTH);
               if (div_zero) begin
                  result_d = funct3[1] ? opA : '1;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : opA;
                  state_d  = DONE;
               end else begin
                  opnd_d  = is_div ? mag_b : mag_a;
                  work_d  = {{(WIDTH+1){1'b0}}, (is_div ? mag_a : mag_b)};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               work_d = step;
               cnt_d  = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
                  if (op_q[2]) begin
                     result_d = op_q[1] ? rem_fix : quot_fix;
                  end else begin
                     result_d = (op_q == F3_MUL) ? prod_fix[WIDTH-1:0]
                                                 : prod_fix[2*WIDTH-1:WIDTH];
                  end
               end
            end
         end
         DONE: begin
            if (kill || out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   // A kill in DONE suppresses the result in the same cycle, so no handshake can count.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE) && !kill;
   assign result    = result_q;

endmodule

// File: tb/tb_m_execution_unit.sv
// Self-checking bench for m_execution_unit against a 64-bit arithmetic reference model.
module tb_m_execution_unit;
   import m_ext_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    funct3 = '0;
   logic [W-1:0]  opA = '0;
   logic [W-1:0]  opB = '0;
   logic          kill = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;

   int asserts = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs [13] = '{
      '{F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3"},
      '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones"},
      '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, "mulh_ones"},
      '{F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ones"},
      '{F3_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, "mul_ones"},
      '{F3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_m7_2"},
      '{F3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_m7_2"},
      '{F3_DIVU,   32'd100,        32'd7,        32'd14,       "divu_100_7"},
      '{F3_REMU,   32'd100,        32'd7,        32'd2,        "remu_100_7"},
      '{F3_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, "div_by_zero"},
      '{F3_REM,    32'd5,          32'd0,        32'd5,        "rem_by_zero"},
      '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf"},
      '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, "rem_ovf"}
   };

   m_execution_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
      .opA(opA), .opB(opB), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
      .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0]        p;
      logic signed [31:0] q;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      p  = '0;
      q  = '0;
      case (f3)
         F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * ub; return p[63:32]; end
         F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            q = $signed(a) / $signed(b);
            return q;
         end
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            q = $signed(a) % $signed(b);
            return q;
         end
         F3_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return W + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Presents a request and returns just after its accept edge; scrambles inputs afterwards.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output bit ok);
      int guard = 0;
      @(negedge clk);
      funct3 = f3; opA = a; opB = b; in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      ok = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      opA = $urandom; opB = $urandom; funct3 = 3'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #6;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0)
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, want 1 0 00000000",
                  in_ready, out_valid, result);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed();
      bit ok;
      int lat;
      foreach (vecs[i]) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, ok);
         wait_valid(lat);
         asserts++;
         if (!ok || result !== vecs[i].exp) begin
            fails++;
            $display("FAIL %s: result %h, want %h", vecs[i].name, result, vecs[i].exp);
         end
         asserts++;
         if (lat != ref_latency(vecs[i].f3, vecs[i].a, vecs[i].b)) begin
            fails++;
            $display("FAIL %s_latency: %0d cycles, want %0d", vecs[i].name, lat,
                     ref_latency(vecs[i].f3, vecs[i].a, vecs[i].b));
         end
         handshake();
      end
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      logic [2:0]  f3;
      logic [31:0] a, b, exp;
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom);
         a = pick();
         b = pick();
         exp = ref_model(f3, a, b);
         issue(f3, a, b, ok);
         wait_valid(lat);
         asserts++;
         if (!ok || result !== exp || lat != ref_latency(f3, a, b)) begin
            fails++;
            $display("FAIL random_%0d f3=%0d a=%h b=%h: result %h lat %0d, want %h lat %0d",
                     n, f3, a, b, result, lat, exp, ref_latency(f3, a, b));
         end
         handshake();
      end
   endtask

   task automatic test_latency_hold();
      bit ok;
      bit ready_seen = 1'b0;
      int lat = 1;
      issue(F3_MUL, 32'd7, 32'hFFFFFFFD, ok);
      while (!out_valid && lat < 200) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      asserts++;
      if (lat != 33 || ready_seen) begin
         fails++;
         $display("FAIL mul_latency: %0d cycles in_ready_seen=%b, want 33 and 0", lat, ready_seen);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         asserts++;
         if (out_valid !== 1'b1 || result !== 32'hFFFFFFEB || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_%0d: out_valid=%b result=%h in_ready=%b, want 1 ffffffeb 0",
                     i, out_valid, result, in_ready);
         end
      end
      handshake();
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_kill();
      bit ok;
      bit seen = 1'b0;
      int lat;
      issue(F3_MUL, 32'd123, 32'd456, ok);
      repeat (4) begin @(posedge clk); #1; end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL kill_calc: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      asserts++;
      if (seen) begin
         fails++;
         $display("FAIL kill_no_result: out_valid seen=%b, want 0", seen);
      end
      issue(F3_MULHU, 32'd3, 32'd5, ok);
      wait_valid(lat);
      asserts++;
      if (result !== 32'h0 || lat != 33) begin
         fails++;
         $display("FAIL mulhu_after_kill: result %h lat %0d, want 00000000 33", result, lat);
      end
      handshake();
      // Kill in DONE together with out_ready: the result must be withdrawn.
      issue(F3_DIVU, 32'd100, 32'd7, ok);
      wait_valid(lat);
      @(negedge clk);
      kill = 1'b1; out_ready = 1'b1;
      #1;
      asserts++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL kill_done_valid: out_valid=%b, want 0", out_valid);
      end
      @(posedge clk); #1;
      kill = 1'b0; out_ready = 1'b0;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL kill_done_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      // Kill while idle does not stop an accept.
      kill = 1'b1;
      issue(F3_DIVU, 32'd100, 32'd7, ok);
      kill = 1'b0;
      wait_valid(lat);
      asserts++;
      if (result !== 32'd14 || lat != 33) begin
         fails++;
         $display("FAIL kill_idle: result %h lat %0d, want 0000000e 33", result, lat);
      end
      handshake();
   endtask

   task automatic test_async_reset();
      bit ok;
      int lat;
      issue(F3_MULHU, $urandom, $urandom, ok);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: in_ready=%b out_valid=%b result=%h, want 1 0 00000000",
                  in_ready, out_valid, result);
      end
      @(negedge clk);
      rst = 1'b1;
      issue(F3_DIV, 32'hFFFFFFF9, 32'd2, ok);
      wait_valid(lat);
      asserts++;
      if (result !== 32'hFFFFFFFD || lat != 33) begin
         fails++;
         $display("FAIL after_reset_div: result %h lat %0d, want fffffffd 33", result, lat);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency_hold();
      test_random();
      test_kill();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule
